// File: rtl/fdas_emif_cal_pkg.sv
// Shared types and default constants for the FDAS EMIF calibration supervisor.
package fdas_emif_cal_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      RESET  = 3'd1,
      WAIT   = 3'd2,
      READY  = 3'd3,
      FAILED = 3'd4,
      ERROR  = 3'd5
   } cal_mon_state_t;

   localparam int DEF_RST_PULSE      = 256;
   localparam int DEF_TIMEOUT_CYCLES = 16777215;
   localparam int DEF_MAX_RETRY      = 3;

endpackage

// File: rtl/fdas_sync2.sv
// Parameterised-width two-flop synchroniser, async active-low reset to zero.
module fdas_sync2 #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] meta_q;
   logic [W-1:0] sync_q;

   // metastability stage followed by the stable output stage
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= {W{1'b0}};
         sync_q <= {W{1'b0}};
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/fdas_emif_cal_monitor.sv
// Sequences EMIF resets, supervises calibration with timeout and bounded retries.
// Optional FDAS_CAL_MON_STATS_EN adds a start-to-ready cycle counter on cal_cycles.
module fdas_emif_cal_monitor
   import fdas_emif_cal_pkg::*;
#(
   parameter int NUM_IF         = 2,
   parameter int RST_PULSE      = DEF_RST_PULSE,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
   parameter int MAX_RETRY      = DEF_MAX_RETRY
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [NUM_IF-1:0] cal_success,
   input  logic [NUM_IF-1:0] cal_fail,
   output logic [NUM_IF-1:0] emif_rst_n,
   output logic              ddr_ready,
   output logic              cal_error,
   output logic [3:0]        retry_cnt,
   output logic [NUM_IF-1:0] fail_mask,
   output logic [31:0]       cal_cycles
);

   localparam int RW = $clog2(RST_PULSE + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   cal_mon_state_t    state_q, state_d;
   logic [RW-1:0]     rst_cnt_q, rst_cnt_d;
   logic [TW-1:0]     to_cnt_q, to_cnt_d;
   logic [3:0]        retry_cnt_q, retry_cnt_d;
   logic [NUM_IF-1:0] fail_mask_q, fail_mask_d;
   logic [NUM_IF-1:0] emif_rst_n_q, emif_rst_n_d;
   logic              ddr_ready_q, ddr_ready_d;
   logic              cal_error_q, cal_error_d;
   logic [NUM_IF-1:0] succ_s, fail_s;
   logic              timeout_s, start_acc_s;

   fdas_sync2 #(.W(NUM_IF)) u_sync_success (.clk(clk), .rst_n(rst_n), .d(cal_success), .q(succ_s));
   fdas_sync2 #(.W(NUM_IF)) u_sync_fail    (.clk(clk), .rst_n(rst_n), .d(cal_fail),    .q(fail_s));

   assign timeout_s   = (to_cnt_q == TW'(TIMEOUT_CYCLES - 1));
   assign start_acc_s = start && ((state_q == IDLE) || (state_q == ERROR));

   // state register and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         rst_cnt_q    <= {RW{1'b0}};
         to_cnt_q     <= {TW{1'b0}};
         retry_cnt_q  <= 4'd0;
         fail_mask_q  <= {NUM_IF{1'b0}};
         emif_rst_n_q <= {NUM_IF{1'b0}};
         ddr_ready_q  <= 1'b0;
         cal_error_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         rst_cnt_q    <= rst_cnt_d;
         to_cnt_q     <= to_cnt_d;
         retry_cnt_q  <= retry_cnt_d;
         fail_mask_q  <= fail_mask_d;
         emif_rst_n_q <= emif_rst_n_d;
         ddr_ready_q  <= ddr_ready_d;
         cal_error_q  <= cal_error_d;
      end
   end

   // next-state: fail beats timeout beats all-success
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = RESET; else state_d = IDLE;
         RESET:   if (rst_cnt_q == RW'(RST_PULSE - 1)) state_d = WAIT; else state_d = RESET;
         WAIT: begin
            if ((|fail_s) || timeout_s) state_d = FAILED;
            else if (&succ_s)           state_d = READY;
            else                        state_d = WAIT;
         end
         READY:   if (!(&succ_s)) state_d = FAILED; else state_d = READY;
         FAILED:  if (retry_cnt_q == 4'(MAX_RETRY)) state_d = ERROR; else state_d = RESET;
         ERROR:   if (start) state_d = RESET; else state_d = ERROR;
         default: state_d = IDLE;
      endcase
   end

   // counters, retry bookkeeping and output decode
   always_comb begin
      rst_cnt_d   = {RW{1'b0}};
      to_cnt_d    = {TW{1'b0}};
      retry_cnt_d = retry_cnt_q;
      fail_mask_d = fail_mask_q;
      if ((state_q == RESET) && (state_d == RESET)) begin
         rst_cnt_d = rst_cnt_q + RW'(1);
      end else begin
         rst_cnt_d = {RW{1'b0}};
      end
      if ((state_q == WAIT) && (state_d == WAIT)) begin
         to_cnt_d = (to_cnt_q != {TW{1'b1}}) ? to_cnt_q + TW'(1) : to_cnt_q;
      end else begin
         to_cnt_d = {TW{1'b0}};
      end
      if (start_acc_s) begin
         retry_cnt_d = 4'd0;
         fail_mask_d = {NUM_IF{1'b0}};
      end else if ((state_q == FAILED) && (state_d == RESET)) begin
         retry_cnt_d = retry_cnt_q + 4'd1;
      end else if ((state_q == WAIT) && (state_d == FAILED)) begin
         fail_mask_d = fail_s | (timeout_s ? ~succ_s : {NUM_IF{1'b0}});
      end else if ((state_q == READY) && (state_d == FAILED)) begin
         fail_mask_d = ~succ_s;
      end else begin
         fail_mask_d = fail_mask_q;
      end
      emif_rst_n_d = {NUM_IF{state_d inside {WAIT, READY, FAILED}}};
      // ready is held through the one FAILED cycle that follows a loss
      ddr_ready_d  = (state_d == READY) || ((state_d == FAILED) && (state_q == READY));
      cal_error_d  = (state_d == ERROR);
   end

`ifdef FDAS_CAL_MON_STATS_EN
   logic [31:0] stat_cnt_q, stat_cnt_d;
   logic [31:0] cal_cycles_q, cal_cycles_d;

   // start-to-ready cycle counter, frozen into cal_cycles on READY entry
   always_comb begin
      stat_cnt_d = stat_cnt_q;
      if (start_acc_s) begin
         stat_cnt_d = 32'd0;
      end else if ((state_q inside {RESET, WAIT, FAILED}) && (stat_cnt_q != 32'hFFFF_FFFF)) begin
         stat_cnt_d = stat_cnt_q + 32'd1;
      end else begin
         stat_cnt_d = stat_cnt_q;
      end
      if ((state_d == READY) && (state_q != READY)) cal_cycles_d = stat_cnt_d;
      else                                          cal_cycles_d = cal_cycles_q;
   end

   // statistics registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_cnt_q   <= 32'd0;
         cal_cycles_q <= 32'd0;
      end else begin
         stat_cnt_q   <= stat_cnt_d;
         cal_cycles_q <= cal_cycles_d;
      end
   end

   assign cal_cycles = cal_cycles_q;
`else
   assign cal_cycles = 32'd0;
`endif

   assign emif_rst_n = emif_rst_n_q;
   assign ddr_ready  = ddr_ready_q;
   assign cal_error  = cal_error_q;
   assign retry_cnt  = retry_cnt_q;
   assign fail_mask  = fail_mask_q;

endmodule

// File: tb/tb_fdas_emif_cal_monitor.sv
// Randomized self-checking bench for fdas_emif_cal_monitor; timing expectations are edge counts derived from the calibration rules.
module tb_fdas_emif_cal_monitor;

   localparam int NIF  = 2;
   localparam int RP   = 16;
   localparam int TO   = 1000;
   localparam int MR   = 2;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           start = 1'b0;
   logic [NIF-1:0] cal_success = 2'b00;
   logic [NIF-1:0] cal_fail = 2'b00;
   logic [NIF-1:0] emif_rst_n;
   logic           ddr_ready;
   logic           cal_error;
   logic [3:0]     retry_cnt;
   logic [NIF-1:0] fail_mask;
   logic [31:0]    cal_cycles;

   int cyc = 0;
   int checks = 0;
   int passed = 0;

   fdas_emif_cal_monitor #(.NUM_IF(NIF), .RST_PULSE(RP), .TIMEOUT_CYCLES(TO), .MAX_RETRY(MR)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .cal_success(cal_success), .cal_fail(cal_fail),
      .emif_rst_n(emif_rst_n), .ddr_ready(ddr_ready), .cal_error(cal_error), .retry_cnt(retry_cnt),
      .fail_mask(fail_mask), .cal_cycles(cal_cycles)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] exp_stats(input int ready_at, input int s);
`ifdef FDAS_CAL_MON_STATS_EN
      return 32'(ready_at - s);
`else
      return 32'd0;
`endif
   endfunction

   task automatic reset_dut();
      rst_n = 1'b0; start = 1'b0; cal_success = 2'b00; cal_fail = 2'b00;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   // start sampled at edge s (returned)
   task automatic pulse_start(output int s);
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 s = cyc; start = 1'b0;
   endtask

   // returns edge index after which emif_rst_n first equals val, -1 on bound
   task automatic wait_rst(input logic [NIF-1:0] val, input int limit, output int at);
      at = -1;
      for (int n = 0; n < limit; n++) begin
         @(negedge clk);
         if (emif_rst_n === val) begin at = cyc; break; end
      end
   endtask

   task automatic wait_flag(input int sel, input logic v, input int limit, output int at);
      at = -1;
      for (int n = 0; n < limit; n++) begin
         @(negedge clk);
         if (((sel == 0) ? ddr_ready : cal_error) === v) begin at = cyc; break; end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #12;
      checks++;
      if ({emif_rst_n, ddr_ready, cal_error, retry_cnt, fail_mask, cal_cycles} !== 42'd0)
         $display("FAIL reset_values: got rst=%b rdy=%b err=%b retry=%0d mask=%b cyc=%0d exp all 0",
                  emif_rst_n, ddr_ready, cal_error, retry_cnt, fail_mask, cal_cycles);
      else passed++;
      reset_dut();
   endtask

   task automatic test_nominal();
      int s, at, k, d;
      reset_dut();
      pulse_start(s);
      wait_rst(2'b11, 100, at);
      checks++;
      if (at !== s + RP) $display("FAIL nominal_rst_rise: got edge %0d exp %0d", at, s + RP);
      else passed++;
      d = $urandom_range(150, 300);
      repeat (d) @(posedge clk);
      #1 k = cyc; cal_success = 2'b11;
      wait_flag(0, 1'b1, 20, at);
      checks++;
      if (at !== k + 3) $display("FAIL nominal_ready: got edge %0d exp %0d", at, k + 3);
      else passed++;
      checks++;
      if (retry_cnt !== 4'd0 || fail_mask !== 2'b00 || cal_error !== 1'b0)
         $display("FAIL nominal_status: got retry=%0d mask=%b err=%b exp 0 00 0", retry_cnt, fail_mask, cal_error);
      else passed++;
      checks++;
      if (cal_cycles !== exp_stats(at, s)) $display("FAIL nominal_cycles: got %0d exp %0d", cal_cycles, exp_stats(at, s));
      else passed++;
   endtask

   task automatic test_fail_then_pass();
      int s, at, lo, k, idx;
      logic [NIF-1:0] bit_m;
      reset_dut();
      idx = $urandom_range(0, NIF - 1);
      bit_m = 2'b01 << idx;
      pulse_start(s);
      wait_rst(2'b11, 100, at);
      repeat ($urandom_range(5, 100)) @(posedge clk);
      #1 k = cyc; cal_fail = bit_m;
      repeat (2) @(posedge clk);
      #1 cal_fail = 2'b00;
      wait_rst(2'b00, 20, lo);
      checks++;
      if (lo !== k + 4) $display("FAIL retry_reset_start: got edge %0d exp %0d", lo, k + 4);
      else passed++;
      wait_rst(2'b11, 100, at);
      checks++;
      if (at - lo !== RP) $display("FAIL retry_reset_len: got %0d exp %0d", at - lo, RP);
      else passed++;
      checks++;
      if (retry_cnt !== 4'd1 || fail_mask !== bit_m)
         $display("FAIL retry_status: got retry=%0d mask=%b exp 1 %b", retry_cnt, fail_mask, bit_m);
      else passed++;
      repeat ($urandom_range(1, 50)) @(posedge clk);
      #1 k = cyc; cal_success = 2'b11;
      wait_flag(0, 1'b1, 20, at);
      checks++;
      if (at !== k + 3 || retry_cnt !== 4'd1 || fail_mask !== bit_m)
         $display("FAIL retry_ready: got edge %0d retry=%0d mask=%b exp %0d 1 %b", at, retry_cnt, fail_mask, k + 3, bit_m);
      else passed++;
      checks++;
      if (cal_cycles !== exp_stats(at, s)) $display("FAIL retry_cycles: got %0d exp %0d", cal_cycles, exp_stats(at, s));
      else passed++;
   endtask

   task automatic test_timeout();
      int s, at, j;
      logic [NIF-1:0] succ;
      reset_dut();
      j = $urandom_range(0, NIF - 1);
      succ = 2'b01 << j;
      cal_success = succ;
      pulse_start(s);
      wait_flag(1, 1'b1, (MR + 1) * (RP + TO + 1) + 50, at);
      checks++;
      if (at !== s + (MR + 1) * (RP + TO + 1))
         $display("FAIL timeout_error_edge: got %0d exp %0d", at, s + (MR + 1) * (RP + TO + 1));
      else passed++;
      checks++;
      if (retry_cnt !== 4'(MR) || fail_mask !== ~succ || emif_rst_n !== 2'b00 || ddr_ready !== 1'b0)
         $display("FAIL timeout_status: got retry=%0d mask=%b rst=%b rdy=%b exp %0d %b 00 0",
                  retry_cnt, fail_mask, emif_rst_n, ddr_ready, MR, ~succ);
      else passed++;
      repeat (20) @(posedge clk);
      @(negedge clk);
      checks++;
      if (cal_error !== 1'b1) $display("FAIL error_sticky: got %b exp 1", cal_error);
      else passed++;
      pulse_start(s);
      @(negedge clk);
      checks++;
      if (cal_error !== 1'b0 || retry_cnt !== 4'd0 || fail_mask !== 2'b00 || emif_rst_n !== 2'b00)
         $display("FAIL error_restart: got err=%b retry=%0d mask=%b rst=%b exp 0 0 00 00",
                  cal_error, retry_cnt, fail_mask, emif_rst_n);
      else passed++;
   endtask

   task automatic test_lost_cal();
      int s, at, lo, k, i;
      logic [NIF-1:0] succ;
      reset_dut();
      pulse_start(s);
      wait_rst(2'b11, 100, at);
      #1 cal_success = 2'b11;
      wait_flag(0, 1'b1, 20, at);
      repeat ($urandom_range(1, 30)) @(posedge clk);
      i = $urandom_range(0, NIF - 1);
      succ = 2'b11 & ~(2'b01 << i);
      #1 k = cyc; cal_success = succ;
      wait_flag(0, 1'b0, 20, at);
      checks++;
      if (at !== k + 4) $display("FAIL lost_ready_fall: got edge %0d exp %0d", at, k + 4);
      else passed++;
      checks++;
      if (fail_mask !== ~succ || retry_cnt !== 4'd1 || emif_rst_n !== 2'b00)
         $display("FAIL lost_status: got mask=%b retry=%0d rst=%b exp %b 1 00", fail_mask, retry_cnt, emif_rst_n, ~succ);
      else passed++;
   endtask

   task automatic test_priority();
      int s, at, k, lo;
      bit saw_ready;
      reset_dut();
      pulse_start(s);
      wait_rst(2'b11, 100, at);
      repeat ($urandom_range(1, 40)) @(posedge clk);
      #1 k = cyc; cal_fail = 2'b01; cal_success = 2'b11;
      saw_ready = 1'b0; lo = -1;
      for (int n = 0; n < 8; n++) begin
         @(negedge clk);
         if (ddr_ready === 1'b1) saw_ready = 1'b1;
         if (lo < 0 && emif_rst_n === 2'b00) lo = cyc;
      end
      checks++;
      if (saw_ready !== 1'b0 || lo !== k + 4)
         $display("FAIL priority_fail_wins: got ready_seen=%b rst_low_edge=%0d exp 0 %0d", saw_ready, lo, k + 4);
      else passed++;
      checks++;
      if (fail_mask !== 2'b01 || retry_cnt !== 4'd1)
         $display("FAIL priority_status: got mask=%b retry=%0d exp 01 1", fail_mask, retry_cnt);
      else passed++;
   endtask

   task automatic test_start_ignored_and_async_reset();
      int s, at, bad;
      reset_dut();
      pulse_start(s);
      wait_rst(2'b11, 100, at);
      #1 cal_fail = 2'b10;
      wait_rst(2'b00, 20, at);
      cal_fail = 2'b00;
      wait_rst(2'b11, 100, at);
      repeat (5) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      bad = 0;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (emif_rst_n !== 2'b11 || retry_cnt !== 4'd1) bad++;
      end
      checks++;
      if (bad !== 0) $display("FAIL start_in_wait: got %0d disturbed cycles exp 0", bad);
      else passed++;
      @(posedge clk); #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({emif_rst_n, ddr_ready, cal_error, retry_cnt, fail_mask, cal_cycles} !== 42'd0)
         $display("FAIL async_reset: got rst=%b rdy=%b err=%b retry=%0d mask=%b cyc=%0d exp all 0",
                  emif_rst_n, ddr_ready, cal_error, retry_cnt, fail_mask, cal_cycles);
      else passed++;
      #10 rst_n = 1'b1;
      repeat (30) @(posedge clk);
      @(negedge clk);
      checks++;
      if (emif_rst_n !== 2'b00 || retry_cnt !== 4'd0)
         $display("FAIL post_reset_idle: got rst=%b retry=%0d exp 00 0", emif_rst_n, retry_cnt);
      else passed++;
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_fail_then_pass();
      test_timeout();
      test_lost_cal();
      test_priority();
      test_start_ignored_and_async_reset();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/fdas_emif_cal_monitor.md
# fdas_emif_cal_monitor

Calibration supervisor for the two FDAS DDR EMIF interfaces. It sits directly downstream of the EMIF calibration component and the EMIFs it calibrates. It sequences each EMIF's reset, then watches the per-interface calibration success/fail flags with a timeout. It retries calibration a bounded number of times and presents a single `ddr_ready` / `cal_error` status to the FDAS DDR controller and to host status registers.

## Interface
- `NUM_IF`, 2: number of EMIF interfaces supervised.
- `RST_PULSE`, 256: cycles `emif_rst_n` is held low per attempt (≥2).
- `TIMEOUT_CYCLES`, 16777215: cycles allowed in WAIT before declaring failure (≥1).
- `MAX_RETRY`, 3: retries after the first attempt (0–15).
- `clk` in 1: system clock, same clock as the EMIF calibration bus clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: single-cycle pulse that begins calibration from IDLE or ERROR.
- `cal_success` in NUM_IF: EMIF local calibration success flags; asynchronous to `clk`.
- `cal_fail` in NUM_IF: EMIF local calibration fail flags; asynchronous to `clk`.
- `emif_rst_n` out NUM_IF: per-EMIF reset, active-low, all bits driven together.
- `ddr_ready` out 1: all interfaces calibrated.
- `cal_error` out 1: retries exhausted; sticky.
- `retry_cnt` out 4: retries consumed in the current sequence.
- `fail_mask` out NUM_IF: per-interface fail or timeout cause, latched at the last failed attempt.
- `cal_cycles` out 32: cycles from `start` to `ddr_ready` (see Configuration).

## Operation
- Each `cal_success` / `cal_fail` bit passes through a 2-flop synchroniser before any use.
- States and transitions:
  - IDLE: `emif_rst_n` = 0. On `start` → RESET; `retry_cnt` ← 0 and `fail_mask` ← 0.
  - RESET: `emif_rst_n` = 0 for RST_PULSE cycles, then → WAIT. The timeout counter clears on entry to WAIT.
  - WAIT: `emif_rst_n` = 1.
    - Any synced fail, or timeout counter == TIMEOUT_CYCLES-1 → FAILED. `fail_mask` latches (synced fail) | (timeout ? ~synced success : 0).
    - Otherwise, all synced success → READY.
  - FAILED (1 cycle): if `retry_cnt` == MAX_RETRY → ERROR. Otherwise `retry_cnt`++ and → RESET.
  - READY: `ddr_ready` = 1. If any synced success deasserts → FAILED, with `fail_mask` = ~synced success. That loss consumes a retry.
  - ERROR: `cal_error` = 1, `emif_rst_n` = 0. A `start` pulse → RESET and clears `retry_cnt`, `fail_mask` and `cal_error`.
- Priority within one cycle: fail > timeout > all-success. A success and a fail on the same interface count as a fail.
- `start` is ignored in RESET, WAIT, READY and FAILED.
- Total attempts = MAX_RETRY+1.

## Timing
- Reset values: state IDLE, `emif_rst_n` all 0, `ddr_ready` 0, `cal_error` 0, `retry_cnt` 0, `fail_mask` 0, `cal_cycles` 0.
- All outputs are registered and change on `clk` rising edge.
- `start` at edge t → RESET from t+1. `emif_rst_n` rises at edge t+1+RST_PULSE.
- Input flag change → synced value visible 2 edges later → state change on the 3rd edge. `ddr_ready` rises 3 edges after the last `cal_success` rises.
- `ddr_ready` falls 4 edges after a `cal_success` drops: 3 edges to reach FAILED, then 1 edge leaving it.
- Timeout: WAIT lasting exactly TIMEOUT_CYCLES cycles with no success → FAILED.
- Timeout counter is `$clog2(TIMEOUT_CYCLES+1)` bits wide and saturates. The RESET counter is `$clog2(RST_PULSE+1)` bits wide.
- `rst_n` asserted mid-sequence: immediate return to reset values; no partial state survives.

## Configuration
- `FDAS_CAL_MON_STATS_EN` defined: a 32-bit saturating counter clears on `start` and counts every cycle outside IDLE, READY and ERROR. It freezes on entering READY, and that frozen value drives `cal_cycles`. It holds its value on entering ERROR.
- Not defined: counter absent; `cal_cycles` tied to 0.

## Structure
- `fdas_emif_cal_pkg` holds:
  - the state enum `cal_mon_state_t` (IDLE, RESET, WAIT, READY, FAILED, ERROR);
  - default constants for RST_PULSE, TIMEOUT_CYCLES and MAX_RETRY.
- One sub-module, `fdas_sync2`: a parameterised-width 2-flop synchroniser with async active-low reset to 0. It is instantiated once for `cal_success` and once for `cal_fail`.

## Test plan
Bench parameters: NUM_IF=2, RST_PULSE=16, TIMEOUT_CYCLES=1000, MAX_RETRY=2.
- Nominal: `start`; raise `cal_success`=2'b11 200 cycles after `emif_rst_n` rises → `ddr_ready`=1 3 edges later, `retry_cnt`=0. With stats, `cal_cycles`=1+16+200+3 (±1 per the documented edge).
- Fail then pass: `cal_fail[1]` pulses during attempt 1; success on attempt 2 → `retry_cnt`=1, `fail_mask`=2'b10, `emif_rst_n` low for 16 cycles again, then `ddr_ready`=1.
- Timeout exhaustion: only `cal_success[0]` ever rises → 3 attempts of 1000 WAIT cycles each → `cal_error`=1, `retry_cnt`=2, `fail_mask`=2'b10, `emif_rst_n`=0.
- Lost calibration: in READY, drop `cal_success[0]` → `ddr_ready` falls 4 edges later, `fail_mask`=2'b01, `retry_cnt`=1, new RESET pulse.
- Priority: `cal_fail[0]` and `cal_success`=2'b11 rise in the same cycle → FAILED, never READY.
- Async reset asserted mid-WAIT and `start` pulsed during WAIT → reset: all outputs return to reset values immediately; `start` in WAIT: no state change.
